spi_flash_responder: RTL and testbench

//  SPI target that answers flash READ (0x03) transactions, mode 3 (SCLK idles high), MSB first.

---
 rtl/spi_flash_responder.sv | 169 ++++++++++++++++
 tb/tb_spi_flash_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: mode-3 SPI flash READ (0x03) target fed by a byte memory port; SPI_RESP_FAST_READ_EN adds 0x0B with 8 dummy clocks
module spi_flash_responder #(
  parameter int   ADDR_W      = 24,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              spi_cs_i,
  input  logic              spi_sclk_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  output logic              spi_miso_oe_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              cmd_err_o,
  output logic              underrun_o
);
`ifdef SPI_RESP_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;
  logic fast_q;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_e;
`endif
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic cs_d1_q, sclk_d1_q, cs_s, sclk_s, mosi_s, cs_fall, rise, fall, last_bit;
  logic cmd_ok, addr_done, boundary, ack, ack_use, want;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;
  logic [22:0] rx_q;
  logic [23:0] rx_next;
  logic [7:0] tx_q, tx_d, nbuf_q;
  logic nbuf_valid_q, pend_q, drop_q, mem_req_q, miso_q, miso_d, oe_q, oe_d, cmd_err_q, underrun_q;
  logic [ADDR_W-1:0] addr_q, waddr, mem_addr_q;
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_d1_q & ~cs_s;
  assign rise      = ~cs_s & sclk_s & ~sclk_d1_q;
  assign fall      = ~cs_s & ~sclk_s & sclk_d1_q;
  assign last_bit  = rise & (bit_cnt_q == 3'd7);
  assign rx_next   = {rx_q, mosi_s};
`ifdef SPI_RESP_FAST_READ_EN
  assign cmd_ok    = (rx_next[7:0] == 8'h03) | (rx_next[7:0] == 8'h0B);
`else
  assign cmd_ok    = rx_next[7:0] == 8'h03;
`endif
  assign addr_done = (state_q == ADDR) & last_bit & (byte_cnt_q == 2'd2);
  assign boundary  = (state_q == DATA) & fall & (bit_cnt_q == 3'd0);
  assign ack       = mem_ack_i & mem_req_q;
  assign ack_use   = ack & ~drop_q;
  assign want      = addr_done | boundary;
  assign waddr     = (state_q == ADDR) ? rx_next[ADDR_W-1:0] : addr_q + ADDR_W'(1);
  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign busy_o        = ~cs_s;
  assign cmd_err_o     = cmd_err_q;
  assign underrun_o    = underrun_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (cs_s) state_d = IDLE;
    else
      case (state_q)
        IDLE:    state_d = CMD;
        CMD:     if (last_bit) state_d = cmd_ok ? ADDR : IGNORE;
`ifdef SPI_RESP_FAST_READ_EN
        ADDR:    if (addr_done) state_d = fast_q ? DUMMY : DATA;
        DUMMY:   if (last_bit) state_d = DATA;
`else
        ADDR:    if (addr_done) state_d = DATA;
`endif
        default: state_d = state_q;
      endcase
  end
  // A fetch acked on the boundary edge itself goes straight into the shifter
  always_comb begin
    tx_d   = boundary ? (ack_use ? mem_rdata_i : nbuf_valid_q ? nbuf_q : 8'h00)
           : ((state_q == DATA) & fall) ? {tx_q[6:0], 1'b0} : tx_q;
    oe_d   = state_d == DATA;
    miso_d = oe_d ? tx_d[7] : IDLE_MISO;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      cs_d1_q     <= 1'b1;
      sclk_d1_q   <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_d1_q     <= cs_s;
      sclk_d1_q   <= sclk_s;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      nbuf_q       <= '0;
      nbuf_valid_q <= 1'b0;
      pend_q       <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_req_q    <= 1'b0;
      miso_q       <= IDLE_MISO;
      oe_q         <= 1'b0;
      cmd_err_q    <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
      fast_q       <= 1'b0;
`endif
    end else begin
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      cmd_err_q <= (state_q == CMD) & last_bit & ~cmd_ok;
      if (cs_s) bit_cnt_q <= '0;
      else if (rise) bit_cnt_q <= bit_cnt_q + 3'd1;
      if (rise) rx_q <= rx_next[22:0];
      if (state_q != ADDR) byte_cnt_q <= '0;
      else if (last_bit) byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef SPI_RESP_FAST_READ_EN
      if ((state_q == CMD) & last_bit) fast_q <= rx_next[7:0] == 8'h0B;
`endif
      if (cs_fall) underrun_q <= 1'b0;
      else if (boundary & ~ack_use & ~nbuf_valid_q) underrun_q <= 1'b1;
      if (ack_use) begin
        nbuf_q       <= mem_rdata_i;
        nbuf_valid_q <= 1'b1;
      end
      if (boundary | cs_s) nbuf_valid_q <= 1'b0;
      if (ack) begin
        mem_req_q <= 1'b0;
        drop_q    <= 1'b0;
      end
      // A still-pending fetch at a new request is stale: drop its data and refetch
      if (want) begin
        addr_q <= waddr;
        if (!mem_req_q) begin
          mem_req_q  <= 1'b1;
          mem_addr_q <= waddr;
        end else begin
          pend_q <= 1'b1;
          if (!ack) drop_q <= 1'b1;
        end
      end else if (pend_q & ~mem_req_q) begin
        mem_req_q  <= 1'b1;
        mem_addr_q <= addr_q;
        pend_q     <= 1'b0;
      end
      if (cs_s) begin
        pend_q <= 1'b0;
        if (mem_req_q & ~ack) drop_q <= 1'b1;
      end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI READ transactions against a byte memory model
module tb_spi_flash_responder;
  logic clk = 1'b0;
  logic rst_n, spi_cs, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;
  logic mem_req, mem_ack, busy, cmd_err, underrun;
  logic [23:0] mem_addr;
  logic [7:0] mem_rdata, r;
  int total = 0, bad = 0, ack_dly = 1;
  int err_cyc = 0, oe_cyc = 0, req_cyc = 0, e0, o0, q0;
  logic [7:0] mem [logic [23:0]];
  logic [23:0] addr_log[$];
  always #5 clk = ~clk;
  spi_flash_responder dut (
    .clk_i(clk), .rst_ni(rst_n), .spi_cs_i(spi_cs), .spi_sclk_i(spi_sclk), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso), .spi_miso_oe_o(spi_miso_oe), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata), .busy_o(busy), .cmd_err_o(cmd_err), .underrun_o(underrun)
  );
  function automatic logic [7:0] rd(input logic [23:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic spi_bits(input int n, input logic [7:0] b, output logic [7:0] rv);
    rv = '0;
    for (int i = 0; i < n; i++) begin
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      #80;
      rv = {rv[6:0], spi_miso};
      spi_sclk = 1'b1;
      #80;
    end
  endtask
  task automatic read_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] d;
    spi_cs = 1'b0;
    #100;
    spi_bits(8, op, d);
    spi_bits(8, a[23:16], d);
    spi_bits(8, a[15:8], d);
    spi_bits(8, a[7:0], d);
  endtask
  task automatic cs_off;
    spi_cs = 1'b1;
    #200;
  endtask
  always @(posedge clk) begin
    if (cmd_err) err_cyc++;
    if (spi_miso_oe) oe_cyc++;
    if (mem_req) req_cyc++;
  end
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req === 1'b1) begin
        addr_log.push_back(mem_addr);
        repeat (ack_dly) @(posedge clk);
        #1;
        mem_rdata = rd(mem_addr);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
    end
  end
  initial begin
    rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b1; spi_mosi = 1'b0;
    mem[24'h10] = 8'hA5; mem[24'h11] = 8'h5A; mem[24'h12] = 8'h0F; mem[24'h13] = 8'hF0;
    mem[24'hFFFFFF] = 8'h11; mem[24'h0] = 8'h22;
    mem[24'h100] = 8'hB6; mem[24'h200] = 8'hC3;
    mem[24'h300] = 8'h77; mem[24'h301] = 8'hE1; mem[24'h40] = 8'h6E;
    #20;
    chk("rst_miso", spi_miso, 1);
    chk("rst_oe", spi_miso_oe, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmderr", cmd_err, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    #100;
    addr_log.delete();
    read_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 4; i++) begin
      spi_bits(8, 8'h00, r);
      chk($sformatf("rdA_byte%0d", i), r, mem[24'h10 + 24'(i)]);
    end
    chk("rdA_oe", spi_miso_oe, 1);
    chk("rdA_busy", busy, 1);
    cs_off;
    chk("rdA_underrun", underrun, 0);
    chk("rdA_idle_busy", busy, 0);
    chk("rdA_idle_oe", spi_miso_oe, 0);
    chk("rdA_nreq", addr_log.size(), 5);
    chk("rdA_req0", addr_log[0], 24'h10);
    chk("rdA_req4", addr_log[4], 24'h14);
    addr_log.delete();
    read_hdr(8'h03, 24'hFFFFFF);
    spi_bits(8, 8'h00, r);
    chk("wrap_byte0", r, 8'h11);
    spi_bits(8, 8'h00, r);
    chk("wrap_byte1", r, 8'h22);
    cs_off;
    chk("wrap_nreq", addr_log.size(), 3);
    chk("wrap_req0", addr_log[0], 24'hFFFFFF);
    chk("wrap_req1", addr_log[1], 24'h000000);
    chk("wrap_req2", addr_log[2], 24'h000001);
    e0 = err_cyc; o0 = oe_cyc; q0 = req_cyc;
    spi_cs = 1'b0;
    #100;
    spi_bits(8, 8'h9F, r);
    for (int i = 0; i < 4; i++) spi_bits(8, 8'hFF, r);
    chk("bad_busy", busy, 1);
    cs_off;
    chk("bad_cmderr", err_cyc - e0, 1);
    chk("bad_oe", oe_cyc - o0, 0);
    chk("bad_req", req_cyc - q0, 0);
    read_hdr(8'h03, 24'h000100);
    spi_bits(3, 8'h00, r);
    chk("abort_bits", r, 8'h05);
    cs_off;
    read_hdr(8'h03, 24'h000200);
    spi_bits(8, 8'h00, r);
    chk("abort_next", r, 8'hC3);
    cs_off;
    ack_dly = 20;
    addr_log.delete();
    read_hdr(8'h03, 24'h000300);
    spi_bits(8, 8'h00, r);
    chk("ur_byte0", r, 8'h00);
    chk("ur_flag", underrun, 1);
    spi_bits(8, 8'h00, r);
    chk("ur_byte1", r, 8'hE1);
    cs_off;
    #300;
    chk("ur_sticky", underrun, 1);
    chk("ur_req1", addr_log[1], 24'h301);
    ack_dly = 1;
    spi_cs = 1'b0;
    #100;
    chk("ur_clear", underrun, 0);
    cs_off;
    read_hdr(8'h03, 24'h000010);
    spi_bits(8, 8'h00, r);
    spi_bits(4, 8'h00, r);
    chk("mid_pre_oe", spi_miso_oe, 1);
    chk("mid_pre_addr", mem_addr, 24'h12);
    rst_n = 1'b0;
    #2;
    chk("mid_miso", spi_miso, 1);
    chk("mid_oe", spi_miso_oe, 0);
    chk("mid_req", mem_req, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_busy", busy, 0);
    chk("mid_underrun", underrun, 0);
    chk("mid_cmderr", cmd_err, 0);
    #8;
    spi_cs = 1'b1; spi_sclk = 1'b1;
    #20;
    rst_n = 1'b1;
    #100;
    read_hdr(8'h03, 24'h000013);
    spi_bits(8, 8'h00, r);
    chk("post_rst_byte", r, 8'hF0);
    cs_off;
`ifdef SPI_RESP_FAST_READ_EN
    read_hdr(8'h0B, 24'h000040);
    spi_bits(4, 8'h00, r);
    chk("fast_dummy_oe", spi_miso_oe, 0);
    spi_bits(4, 8'h00, r);
    spi_bits(8, 8'h00, r);
    chk("fast_byte", r, 8'h6E);
    cs_off;
`else
    e0 = err_cyc; o0 = oe_cyc; q0 = req_cyc;
    read_hdr(8'h0B, 24'h000040);
    spi_bits(8, 8'h00, r);
    cs_off;
    chk("fast_off_cmderr", err_cyc - e0, 1);
    chk("fast_off_oe", oe_cyc - o0, 0);
    chk("fast_off_req", req_cyc - q0, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
